// File: rtl/sockit_spi_xip_seq.sv
// XIP read sequencer: turns one flash read request into serializer command/write-data words
// (opcode, address, dummy, data, deselect) and forwards the returned read words.
module sockit_spi_xip_seq #(
    parameter int unsigned SSW = 8,
    parameter int unsigned AAW = 32,
    parameter int unsigned LW  = 8,
    parameter int unsigned CNW = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [7:0]     cfg_opc,
    input  logic           cfg_adr4,
    input  logic [1:0]     cfg_iom_adr,
    input  logic [1:0]     cfg_iom_dat,
    input  logic [3:0]     cfg_dmy,
    input  logic           req_vld,
    output logic           req_rdy,
    input  logic [AAW-1:0] req_adr,
    input  logic [LW-1:0]  req_len,
    output logic           cmd_vld,
    input  logic           cmd_rdy,
    output logic           cmd_sso,
    output logic           cmd_cke,
    output logic [1:0]     cmd_iom,
    output logic           cmd_die,
    output logic           cmd_doe,
    output logic [CNW-1:0] cmd_cnt,
    output logic           dtw_vld,
    input  logic           dtw_rdy,
    output logic [31:0]    dtw_dat,
    input  logic           dtr_vld,
    input  logic [31:0]    dtr_dat,
    output logic           rsp_vld,
    output logic [31:0]    rsp_dat,
    output logic           rsp_lst,
    output logic           busy
);

    // Slave select width only has to agree with the serializer; nothing here depends on it.
    if (SSW == 0) begin : g_ssw_unused
    end

    typedef enum logic [2:0] {
        S_IDLE, S_OPC, S_ADR, S_DMY, S_DAT, S_END, S_WAIT
    } state_t;

    state_t         r_state, w_nxt;
    logic           r_adr4;
    logic [1:0]     r_iom_adr, r_iom_dat;
    logic [3:0]     r_dmy;
    logic [31:0]    r_adr;
    logic [LW-1:0]  r_len;
    logic [LW:0]    r_iss;
    logic [LW-1:0]  r_rcv;
    logic           r_rcv_done;

    logic           r_cmd_vld, r_cmd_sso, r_cmd_cke, r_cmd_die, r_cmd_doe;
    logic [1:0]     r_cmd_iom;
    logic [CNW-1:0] r_cmd_cnt;
    logic           r_dtw_vld;
    logic [31:0]    r_dtw_dat;
    logic           r_rsp_vld, r_rsp_lst, r_busy;
    logic [31:0]    r_rsp_dat;

    logic           w_hs, w_load, w_dtr_acc;
    logic           w_cmd_vld, w_cmd_sso, w_cmd_cke, w_cmd_die, w_cmd_doe, w_dtw_vld;
    logic [1:0]     w_cmd_iom;
    logic [CNW-1:0] w_cmd_cnt;
    logic [31:0]    w_dtw_dat;

    function automatic logic [CNW-1:0] f_cnt(input logic [1:0] iom, input logic [5:0] bits);
        case (iom)
            2'd3:    return CNW'(bits >> 2);
            2'd2:    return CNW'(bits >> 1);
            default: return CNW'(bits);
        endcase
    endfunction

    always_comb begin
        // A phase is complete once both its command and (if any) write-data word were taken.
        w_hs   = (~r_cmd_vld | cmd_rdy) & (~r_dtw_vld | dtw_rdy);
        w_nxt  = r_state;
        w_load = 1'b0;
        case (r_state)
            S_IDLE: if (req_vld) begin w_nxt = S_OPC; w_load = 1'b1; end
            S_OPC:  if (w_hs) begin w_nxt = S_ADR; w_load = 1'b1; end
            S_ADR:  if (w_hs) begin w_nxt = (r_dmy != 4'd0) ? S_DMY : S_DAT; w_load = 1'b1; end
            S_DMY:  if (w_hs) begin w_nxt = S_DAT; w_load = 1'b1; end
            S_DAT:  if (w_hs) begin w_nxt = (r_iss == {1'b0, r_len}) ? S_END : S_DAT; w_load = 1'b1; end
            S_END:  if (w_hs) begin w_nxt = S_WAIT; w_load = 1'b1; end
            S_WAIT: if (r_rcv_done) begin w_nxt = S_IDLE; w_load = 1'b1; end
            default: begin w_nxt = S_IDLE; w_load = 1'b1; end
        endcase

        w_cmd_vld = 1'b0;
        w_cmd_sso = 1'b0;
        w_cmd_cke = 1'b0;
        w_cmd_iom = 2'd1;
        w_cmd_die = 1'b0;
        w_cmd_doe = 1'b0;
        w_cmd_cnt = '0;
        w_dtw_vld = 1'b0;
        w_dtw_dat = '0;
        case (w_nxt)
            S_OPC: begin
                w_cmd_vld = 1'b1; w_cmd_sso = 1'b1; w_cmd_cke = 1'b1; w_cmd_doe = 1'b1;
                w_cmd_cnt = CNW'(8);
                w_dtw_vld = 1'b1;
                w_dtw_dat = {cfg_opc, 24'h0};
            end
            S_ADR: begin
                w_cmd_vld = 1'b1; w_cmd_sso = 1'b1; w_cmd_cke = 1'b1; w_cmd_doe = 1'b1;
                w_cmd_iom = r_iom_adr;
                w_cmd_cnt = f_cnt(r_iom_adr, r_adr4 ? 6'd32 : 6'd24);
                w_dtw_vld = 1'b1;
                w_dtw_dat = r_adr4 ? r_adr : {r_adr[23:0], 8'h00};
            end
            S_DMY: begin
                w_cmd_vld = 1'b1; w_cmd_sso = 1'b1; w_cmd_cke = 1'b1;
                w_cmd_iom = r_iom_dat;
                w_cmd_cnt = CNW'(r_dmy);
            end
            S_DAT: begin
                w_cmd_vld = 1'b1; w_cmd_sso = 1'b1; w_cmd_cke = 1'b1; w_cmd_die = 1'b1;
                w_cmd_iom = r_iom_dat;
                w_cmd_cnt = f_cnt(r_iom_dat, 6'd32);
            end
            S_END: begin
                w_cmd_vld = 1'b1;
                w_cmd_cnt = CNW'(1);
            end
            default: ;
        endcase

        w_dtr_acc = dtr_vld & ~r_rcv_done &
                    ((r_state == S_DAT) | (r_state == S_END) | (r_state == S_WAIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_adr4     <= 1'b0;
            r_iom_adr  <= '0;
            r_iom_dat  <= '0;
            r_dmy      <= '0;
            r_adr      <= '0;
            r_len      <= '0;
            r_iss      <= '0;
            r_rcv      <= '0;
            r_rcv_done <= 1'b0;
            r_cmd_vld  <= 1'b0;
            r_cmd_sso  <= 1'b0;
            r_cmd_cke  <= 1'b0;
            r_cmd_iom  <= 2'd1;
            r_cmd_die  <= 1'b0;
            r_cmd_doe  <= 1'b0;
            r_cmd_cnt  <= '0;
            r_dtw_vld  <= 1'b0;
            r_dtw_dat  <= '0;
            r_rsp_vld  <= 1'b0;
            r_rsp_dat  <= '0;
            r_rsp_lst  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            if (w_load) begin
                r_state   <= w_nxt;
                r_busy    <= (w_nxt != S_IDLE);
                r_cmd_vld <= w_cmd_vld;
                r_cmd_sso <= w_cmd_sso;
                r_cmd_cke <= w_cmd_cke;
                r_cmd_iom <= w_cmd_iom;
                r_cmd_die <= w_cmd_die;
                r_cmd_doe <= w_cmd_doe;
                r_cmd_cnt <= w_cmd_cnt;
                r_dtw_vld <= w_dtw_vld;
                r_dtw_dat <= w_dtw_dat;
            end else begin
                // Partial handshake in OPC/ADR: retire whichever side was taken, hold the other.
                r_cmd_vld <= r_cmd_vld & ~cmd_rdy;
                r_dtw_vld <= r_dtw_vld & ~dtw_rdy;
            end

            if (r_state == S_IDLE && req_vld) begin
                r_adr4     <= cfg_adr4;
                r_iom_adr  <= cfg_iom_adr;
                r_iom_dat  <= cfg_iom_dat;
                r_dmy      <= cfg_dmy;
                r_adr      <= req_adr[31:0];
                r_len      <= req_len;
                r_iss      <= '0;
                r_rcv      <= '0;
                r_rcv_done <= 1'b0;
            end

            if (r_state == S_DAT && r_cmd_vld && cmd_rdy)
                r_iss <= r_iss + 1'b1;

            r_rsp_vld <= w_dtr_acc;
            r_rsp_lst <= w_dtr_acc & (r_rcv == r_len);
            if (w_dtr_acc) begin
                r_rsp_dat <= dtr_dat;
                r_rcv     <= r_rcv + 1'b1;
                if (r_rcv == r_len)
                    r_rcv_done <= 1'b1;
            end
        end
    end

    assign req_rdy = (r_state == S_IDLE);
    assign cmd_vld = r_cmd_vld;
    assign cmd_sso = r_cmd_sso;
    assign cmd_cke = r_cmd_cke;
    assign cmd_iom = r_cmd_iom;
    assign cmd_die = r_cmd_die;
    assign cmd_doe = r_cmd_doe;
    assign cmd_cnt = r_cmd_cnt;
    assign dtw_vld = r_dtw_vld;
    assign dtw_dat = r_dtw_dat;
    assign rsp_vld = r_rsp_vld;
    assign rsp_dat = r_rsp_dat;
    assign rsp_lst = r_rsp_lst;
    assign busy    = r_busy;

endmodule

// File: doc/sockit_spi_xip_seq.md
Name: sockit_spi_xip_seq

Overview:
- Sequences the SPI serializer for execute-in-place (XIP) flash reads.
- Accepts one read request (address, word count) at a time.
- Emits the command and write-data stream words for the serializer: opcode, address, dummy, data-read and slave-deselect phases.
- Forwards serializer read data back to the requester with a last-word flag.
- Sits between the XIP bus adapter and the serializer's command/data queues.

Parameters:
- SSW, 8, slave select width; must match the serializer.
- AAW, 32, request address width; only the low 24 or 32 bits are used.
- LW, 8, request length field width.
- CNW, 6, command cycle count field width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- cfg_opc  in  8  read opcode
- cfg_adr4  in  1  1 = 32-bit address, 0 = 24-bit address
- cfg_iom_adr  in  2  IO mode for the address phase (0/1 single, 2 dual, 3 quad)
- cfg_iom_dat  in  2  IO mode for the dummy and data phases
- cfg_dmy  in  4  dummy cycle count; 0 skips the dummy phase
- req_vld  in  1  request valid
- req_rdy  out  1  request ready
- req_adr  in  AAW  byte address
- req_len  in  LW  number of 32-bit words minus 1
- cmd_vld  out  1  command word valid
- cmd_rdy  in  1  serializer accepts command
- cmd_sso  out  1  slave select active
- cmd_cke  out  1  SPI clock enable
- cmd_iom  out  2  IO mode
- cmd_die  out  1  data input enable
- cmd_doe  out  1  data output enable
- cmd_cnt  out  CNW  SPI clock cycles for this command
- dtw_vld  out  1  write data valid
- dtw_rdy  in  1  write data accepted
- dtw_dat  out  32  write data, MSB transmitted first
- dtr_vld  in  1  serializer read word valid
- dtr_dat  in  32  serializer read word
- rsp_vld  out  1  response word valid
- rsp_dat  out  32  response word
- rsp_lst  out  1  last word of the request
- busy  out  1  transaction in progress

Behaviour:
- Reset: state IDLE. Outputs cmd_vld, dtw_vld, rsp_vld, rsp_lst, busy, cmd_sso, cmd_cke, cmd_die, cmd_doe are 0. cmd_iom = 1, cmd_cnt = 0, dtw_dat = 0. All counters are 0.
- Reset asserted mid-transaction aborts at once; in-flight read data arriving after reset release is ignored.
- Bits per cycle (bpc) from IO mode: iom 0 or 1 → 1, 2 → 2, 3 → 4.
- req_rdy = 1 only in IDLE.
  - Handshake req_vld & req_rdy latches the request and all cfg_* fields.
  - cfg changes during a transaction have no effect.
  - busy rises on the next clk.
- Command issue rule:
  - Each state presents one command word with cmd_vld = 1.
  - The state advances on the clk where cmd_vld & cmd_rdy is seen.
  - The command and its fields are held stable while cmd_rdy = 0.
  - No combinational path from cmd_rdy to cmd_* fields.
- Write-data pairing:
  - In OPC and ADR, dtw_vld is raised with cmd_vld; each handshakes independently.
  - The state advances only when both handshakes have completed, in either order or on the same clk.
- FSM states and command words:
  - IDLE → OPC on request accept.
  - OPC: sso=1, cke=1, iom=1, doe=1, die=0, cnt=8; dtw_dat = {opc, 24'h0}. Next state ADR.
  - ADR: sso=1, cke=1, iom=cfg_iom_adr, doe=1, die=0, cnt = (adr4 ? 32 : 24)/bpc.
    - dtw_dat = adr4 ? adr[31:0] : {adr[23:0], 8'h00}.
    - Next state DMY if cfg_dmy ≠ 0, else DAT.
  - DMY: sso=1, cke=1, iom=cfg_iom_dat, doe=0, die=0, cnt=cfg_dmy. Next state DAT.
  - DAT: sso=1, cke=1, iom=cfg_iom_dat, doe=0, die=1, cnt = 32/bpc. One command per word; the issued-word counter increments per handshake. After req_len+1 words, next state END.
  - END: sso=0, cke=0, doe=0, die=0, cnt=1 (deselect gap). Next state WAIT.
  - WAIT: stays until all req_len+1 response words are forwarded, then IDLE; busy falls the same clk.
- Response path:
  - rsp_vld/rsp_dat are dtr_vld/dtr_dat registered by 1 clk.
  - rsp_lst = 1 on the response word whose count equals req_len.
  - No back-pressure on rsp.
  - dtr_vld outside a transaction (busy = 0, not WAIT or DAT) is dropped.
- Received-word counter (LW bits) and issued-word counter (LW+1 bits) clear on request accept.
  - req_len = 2^LW − 1 must not overflow.
  - req_len = 0 gives exactly one DAT command.

Test Plan:
- Single quad read: cfg_opc=8'hEB, adr4=0, iom_adr=3, iom_dat=3, dmy=4, req_adr=24'h123456, req_len=0, cmd_rdy/dtw_rdy tied 1 → commands OPC(cnt 8, dtw 32'hEB000000), ADR(iom 3, cnt 6, dtw 32'h12345600), DMY(cnt 4), DAT(die 1, cnt 8), END(sso 0, cnt 1); one response word with rsp_lst=1; busy returns to 0.
- Single-wire 32-bit address, dmy=0, req_len=3 → ADR cnt=32, DMY skipped, 4 DAT commands with cnt=32, 4 responses, rsp_lst only on the 4th.
- Back-pressure: cmd_rdy toggles 1 clk on / 2 off, dtw_rdy delayed 3 clks in OPC → all fields stable while stalled, no command dropped or duplicated, order unchanged.
- req_vld held 1 throughout → second request accepted only on the first clk back in IDLE (req_rdy=1); no overlap of commands between requests.
- rst_n pulsed low during DAT of a req_len=7 transfer → all valids 0 and state IDLE asynchronously; next request runs normally from OPC.
- Stray dtr_vld pulse while IDLE → no rsp_vld; config change mid-transfer (iom_dat 3→1) → remaining DAT commands keep iom=3, cnt=8.
